// File: rtl/rr_arb_mux.sv
// rr_arb_mux: registered N:1 valid/ready mux with an internal round-robin or
// fixed-priority arbiter that holds its grant until a packet's last beat.
module rr_arb_mux #(
  parameter int W    = 32,
  parameter int N    = 4,
  parameter int SELW = 2,
  parameter int MODE = 0
) (
  input  logic            clk,
  input  logic            reset,
  input  logic [N*W-1:0]  in_data,
  input  logic [N-1:0]    in_valid,
  input  logic [N-1:0]    in_last,
  output logic [N-1:0]    in_ready,
  output logic [W-1:0]    out_data,
  output logic [SELW-1:0] out_sel,
  output logic            out_last,
  output logic            out_valid,
  input  logic            out_ready
);
  typedef enum logic {ARB, LOCKED} state_t;
  state_t          r_state, w_state_nxt;
  logic [SELW-1:0] r_ptr, r_lock, w_grant, w_ptr_nxt, w_off;
  logic [SELW:0]   w_sum;
  logic [N-1:0]    w_rot;
  logic [W-1:0]    w_data;
  logic            w_any, w_gnt_vld, w_load, w_xfer, w_last;
  assign w_load = !out_valid || out_ready;
  // Rotate valids so the search always starts at bit 0; ptr stays 0 in fixed-priority mode.
  assign w_rot = N'({in_valid, in_valid} >> r_ptr);
  always_comb begin
    w_off = '0;
    w_any = 1'b0;
    for (int i = N - 1; i >= 0; i--)
      if (w_rot[i]) begin
        w_off = SELW'(i);
        w_any = 1'b1;
      end
    w_sum = {1'b0, r_ptr} + {1'b0, w_off};
    w_grant = (r_state == LOCKED) ? r_lock
            : SELW'((w_sum >= (SELW+1)'(N)) ? w_sum - (SELW+1)'(N) : w_sum);
    w_gnt_vld = (r_state == LOCKED) || w_any;
  end
  always_comb begin
    w_data = '0;
    w_last = 1'b0;
    in_ready = '0;
    for (int k = 0; k < N; k++)
      if (w_grant == SELW'(k)) begin
        w_data = in_data[k*W +: W];
        w_last = in_last[k];
        in_ready[k] = w_load && w_gnt_vld && !reset;
      end
  end
  assign w_xfer = |(in_valid & in_ready);
  always_comb begin
    w_state_nxt = r_state;
    w_ptr_nxt = r_ptr;
    if (w_xfer) begin
      w_state_nxt = w_last ? ARB : LOCKED;
      if (w_last && MODE == 0) w_ptr_nxt = (w_grant == SELW'(N - 1)) ? '0 : w_grant + 1'b1;
    end
  end
  always_ff @(posedge clk or posedge reset)
    if (reset) begin
      r_state <= ARB;
      r_ptr <= '0;
      r_lock <= '0;
      out_valid <= 1'b0;
      out_data <= '0;
      out_sel <= '0;
      out_last <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      r_ptr <= w_ptr_nxt;
      if (w_load) out_valid <= w_xfer;
      if (w_xfer) begin
        r_lock <= w_grant;
        out_data <= w_data;
        out_sel <= w_grant;
        out_last <= w_last;
      end
    end
endmodule

// File: doc/rr_arb_mux.md
Name: rr_arb_mux

Overview:
- Registered N-input, W-bit multiplexer with valid/ready handshakes on every input and on the output.
- Selection is no longer driven externally: an internal arbiter picks the channel, either round-robin or fixed-priority.
- The arbiter holds a grant across multi-beat packets until the packet's last beat.
- Sits in front of shared DSP datapath stages so several sample streams can share one consumer.

Parameters:
- W, 32, data width per channel.
- N, 4, number of input channels (2..16; need not be a power of two).
- SELW, 2, width of the channel index; 2^SELW >= N required.
- MODE, 0, arbitration policy: 0 = round-robin, 1 = fixed priority (lowest index wins).

Ports:
- clk  input  1  single clock, rising edge.
- reset  input  1  asynchronous, active-high reset.
- in_data  input  N*W  channel data; channel k occupies bits [k*W+W-1 : k*W].
- in_valid  input  N  per-channel valid.
- in_last  input  N  per-channel last-beat-of-packet flag; sampled only with a transfer.
- in_ready  output  N  per-channel ready; at most one bit high in any cycle.
- out_data  output  W  registered selected data.
- out_sel  output  SELW  index of the channel that produced out_data.
- out_last  output  1  registered last flag of the current output beat.
- out_valid  output  1  output beat valid.
- out_ready  input  1  downstream ready.

Behaviour:
- Reset (async assert, sync release) clears:
  - out_valid=0, out_data=0, out_sel=0, out_last=0.
  - Round-robin pointer ptr=0; state=ARB.
  - in_ready=0 while reset is high.
- Load enable: load = !out_valid || out_ready.
- Input transfer on channel k: in_valid[k] && in_ready[k].
- Output transfer: out_valid && out_ready.
- in_ready is combinational: in_ready[k] = load && (grant == k) && !reset. Valid and data are never gated combinationally to the output.
- Latency is exactly 1 cycle from input transfer to out_valid. Throughput is 1 beat/cycle when out_ready is held high.
- Output register on a load cycle:
  - If an input transfer occurs: out_data, out_sel and out_last capture the granted channel; out_valid=1.
  - If no transfer occurs: out_valid=0; data fields hold their previous values.
- Output register when not loading: all output registers hold. Stable out_data/out_sel while out_valid && !out_ready is mandatory.
- State machine, two states:
  - ARB: grant = first k with in_valid[k] set.
    - MODE=0: search order ptr, ptr+1, ..., N-1, 0, ..., ptr-1.
    - MODE=1: search order 0..N-1.
    - No valid channel: no grant, all in_ready=0.
    - On transfer with in_last=0: go to LOCKED with lock_ch=grant.
    - On transfer with in_last=1: stay in ARB.
  - LOCKED: grant = lock_ch only, regardless of other valids.
    - If in_valid[lock_ch]=0, the cycle is a bubble and other channels are not served.
    - On transfer with in_last=1: return to ARB.
- Pointer update (MODE=0 only): on the transfer that returns or keeps state at ARB, i.e. on the packet's final beat, ptr <= (grant==N-1) ? 0 : grant+1. The pointer wraps at N, not 2^SELW. In MODE=1, ptr is unused and stays 0.
- Single-beat packets (in_last=1 every beat) give plain per-beat round-robin.
- Simultaneous events: output transfer and new input transfer in the same cycle are allowed; no bubble.
- Downstream stall: while out_valid && !out_ready, all in_ready=0, state and ptr hold, LOCKED persists.
- Reset asserted mid-packet drops the lock immediately. Partial packets are not resumed.
- Channels >= N and unused index codes are never produced on out_sel.

Test Plan:
- Reset held, all in_valid=1 -> in_ready=0, out_valid=0, out_sel=0. Release reset, out_ready=1 -> channel 0 granted first; out_valid=1 one cycle later with out_data=in_data[ch0].
- MODE=0, N=4, all channels valid, single-beat, out_ready=1 -> out_sel sequence 0,1,2,3,0,1 on consecutive cycles with no bubbles.
- MODE=0, N=3, only ch2 and ch0 valid, single-beat -> out_sel alternates 2,0,2,0. Confirms wrap at N=3: after ch2, ptr=0, never 3.
- MODE=0, ch1 sends 3-beat packet (in_last on beat 3) while ch0 and ch2 valid throughout -> out_sel=1,1,1, then 2. Insert ch1 in_valid gap mid-packet -> bubble, ch0/ch2 ready stay 0.
- MODE=1, all valid, single-beat -> out_sel stays 0 every cycle. Drop ch0 valid -> out_sel=1.
- out_ready=0 for 3 cycles with out_valid=1, data 0xA5A5A5A5 -> out_data/out_sel/out_last stable, all in_ready=0. Raise out_ready -> next beat loads same cycle. Assert reset mid-packet -> out_valid=0 immediately, next grant follows ARB from ptr=0.
